// File: rtl/irq_code_latch.sv
// irq_code_latch
//   Registered consumer stage placed directly behind an 8-to-3 priority
//   encoder. The encoder's active-low code and group-select are brought into
//   the clock domain through 2-flop synchronisers. A code is accepted only
//   after it has read identically for STABLE_CYCLES samples, and it is then
//   presented as a true-binary interrupt ID with a valid/ack handshake.
//   While an ID is pending, the encoder is frozen through its EI input.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous, active-low reset
//   a_n[2:0]   encoder {A2,A1,A0}, active-low binary code
//   gs_n       encoder GS, low when any request is active
//   irq_mask   (only with IRQ_CODE_LATCH_MASK_EN) per-ID mask, 1 = masked
//   ei_n       encoder EI, low enables the encoder
//   irq_valid  an accepted ID is pending
//   irq_id     accepted ID, true binary
//   irq_ack    consumer acknowledge, sampled on clk
//
// Optional feature: define IRQ_CODE_LATCH_MASK_EN to add irq_mask.
//
// Parameters
//   STABLE_CYCLES  identical samples needed before acceptance, 1..2^CNT_W-1
//   CNT_W          width of the qualification counter
module irq_code_latch #(
  parameter int STABLE_CYCLES = 2,
  parameter int CNT_W         = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] a_n,
  input  logic       gs_n,
`ifdef IRQ_CODE_LATCH_MASK_EN
  input  logic [7:0] irq_mask,
`endif
  output logic       ei_n,
  output logic       irq_valid,
  output logic [2:0] irq_id,
  input  logic       irq_ack
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] QUAL  = 2'd1;
  localparam logic [1:0] PEND  = 2'd2;
  localparam logic [1:0] BLANK = 2'd3;

  localparam logic [CNT_W-1:0] STABLE_LIM = CNT_W'(STABLE_CYCLES);
  // BLANK covers synchroniser depth + 1 cycles, counted 0..2.
  localparam logic [1:0]       BLANK_LAST = 2'd2;

  logic [2:0]       a_sync_p0, a_sync_p1;
  logic             gs_sync_p0, gs_sync_p1;
  logic [2:0]       code;
  logic             req;
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [2:0]       cand;
  logic [1:0]       blank_cnt;

  // Stage p0/p1: 2-flop synchronisers, reset to "no request".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sync_p0  <= 3'b111;
      a_sync_p1  <= 3'b111;
      gs_sync_p0 <= 1'b1;
      gs_sync_p1 <= 1'b1;
    end else begin
      a_sync_p0  <= a_n;
      a_sync_p1  <= a_sync_p0;
      gs_sync_p0 <= gs_n;
      gs_sync_p1 <= gs_sync_p0;
    end
  end

  assign code = ~a_sync_p1;
`ifdef IRQ_CODE_LATCH_MASK_EN
  assign req  = ~gs_sync_p1 & ~irq_mask[code];
`else
  assign req  = ~gs_sync_p1;
`endif

  // Never wraps: cnt stays below STABLE_CYCLES, so cnt+1 <= 2^CNT_W-1.
  assign cnt_inc = cnt + 1'b1;

  // Stage p2: qualification FSM and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      cand      <= 3'd0;
      blank_cnt <= 2'd0;
      irq_valid <= 1'b0;
      irq_id    <= 3'd0;
      ei_n      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            cand <= code;
            cnt  <= {{(CNT_W-1){1'b0}}, 1'b1};
            if (STABLE_CYCLES == 1) begin
              state     <= PEND;
              irq_valid <= 1'b1;
              irq_id    <= code;
              ei_n      <= 1'b1;
            end else begin
              state <= QUAL;
            end
          end
        end
        QUAL: begin
          if (!req) begin
            state <= IDLE;
          end else if (code != cand) begin
            // A different code restarts qualification on the new value.
            cand <= code;
            cnt  <= {{(CNT_W-1){1'b0}}, 1'b1};
          end else if (cnt_inc >= STABLE_LIM) begin
            state     <= PEND;
            irq_valid <= 1'b1;
            irq_id    <= cand;
            ei_n      <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end
        PEND: begin
          if (irq_ack) begin
            state     <= BLANK;
            irq_valid <= 1'b0;
            ei_n      <= 1'b0;
            cnt       <= '0;
            blank_cnt <= 2'd0;
          end
        end
        default: begin
          // BLANK: let the re-enabled encoder settle through the synchroniser
          // before any GS/code is looked at again.
          if (blank_cnt == BLANK_LAST) begin
            state     <= IDLE;
            blank_cnt <= 2'd0;
          end else begin
            blank_cnt <= blank_cnt + 2'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_code_latch.sv
// tb_irq_code_latch
//   Directed bench for irq_code_latch. Three instances with STABLE_CYCLES of
//   1, 2 and 3 share the same stimulus; each step checks the instance it is
//   aimed at. Expected IDs and acceptance latencies are queued when the
//   stimulus is driven and popped when the instance raises irq_valid.
module tb_irq_code_latch;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] a_n;
  logic       gs_n;
  logic       irq_ack;
`ifdef IRQ_CODE_LATCH_MASK_EN
  logic [7:0] irq_mask;
`endif

  logic       ei1, v1, ei2, v2, ei3, v3;
  logic [2:0] id1, id2, id3;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0] id;
    int         lat;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  irq_code_latch #(.STABLE_CYCLES(1), .CNT_W(4)) u1 (
    .clk(clk), .rst_n(rst_n), .a_n(a_n), .gs_n(gs_n),
`ifdef IRQ_CODE_LATCH_MASK_EN
    .irq_mask(irq_mask),
`endif
    .ei_n(ei1), .irq_valid(v1), .irq_id(id1), .irq_ack(irq_ack));

  irq_code_latch #(.STABLE_CYCLES(2), .CNT_W(4)) u2 (
    .clk(clk), .rst_n(rst_n), .a_n(a_n), .gs_n(gs_n),
`ifdef IRQ_CODE_LATCH_MASK_EN
    .irq_mask(irq_mask),
`endif
    .ei_n(ei2), .irq_valid(v2), .irq_id(id2), .irq_ack(irq_ack));

  irq_code_latch #(.STABLE_CYCLES(3), .CNT_W(4)) u3 (
    .clk(clk), .rst_n(rst_n), .a_n(a_n), .gs_n(gs_n),
`ifdef IRQ_CODE_LATCH_MASK_EN
    .irq_mask(irq_mask),
`endif
    .ei_n(ei3), .irq_valid(v3), .irq_id(id3), .irq_ack(irq_ack));

  function automatic logic vld(input int d);
    case (d)
      1:       return v1;
      2:       return v2;
      default: return v3;
    endcase
  endfunction

  function automatic logic [2:0] idv(input int d);
    case (d)
      1:       return id1;
      2:       return id2;
      default: return id3;
    endcase
  endfunction

  function automatic logic eiv(input int d);
    case (d)
      1:       return ei1;
      2:       return ei2;
      default: return ei3;
    endcase
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    gs_n    = 1'b1;
    a_n     = 3'b111;
    irq_ack = 1'b0;
    steps(2);
    rst_n = 1'b1;
    step();
  endtask

  task automatic push(input logic [2:0] id, input int lat);
    exp_t e;
    e.id  = id;
    e.lat = lat;
    exp_q.push_back(e);
  endtask

  // Count edges until instance d raises irq_valid, then compare against the
  // oldest queued expectation. A missed bound reports latency -1.
  task automatic accept_check(input int d, input string tag);
    exp_t e;
    int   n;
    bit   seen;
    e    = exp_q.pop_front();
    n    = 0;
    seen = 1'b0;
    for (int i = 0; i < e.lat + 6; i++) begin
      step();
      n++;
      if (vld(d)) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_latency"}, seen ? n : -1, e.lat);
    chk({tag, "_id"}, int'(idv(d)), int'(e.id));
    chk({tag, "_ei_n"}, int'(eiv(d)), 1);
  endtask

  initial begin
    int  n;
    bit  seen;
    rst_n   = 1'b0;
    gs_n    = 1'b1;
    a_n     = 3'b111;
    irq_ack = 1'b0;
`ifdef IRQ_CODE_LATCH_MASK_EN
    irq_mask = 8'h00;
`endif
    #1;
    chk("reset_valid", int'(v2), 0);
    chk("reset_id", int'(id2), 0);
    chk("reset_ei_n", int'(ei2), 0);
    steps(2);
    rst_n = 1'b1;
    step();

    // SC=2, code 5: accepted on the 4th edge.
    gs_n = 1'b0;
    a_n  = 3'b010;
    push(3'd5, 4);
    accept_check(2, "sc2_code5");

    // Asynchronous reset while pending.
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_pend_valid", int'(v2), 0);
    chk("rst_pend_id", int'(id2), 0);
    chk("rst_pend_ei_n", int'(ei2), 0);
    gs_n = 1'b1;
    a_n  = 3'b111;
    step();
    rst_n = 1'b1;
    steps(6);
    chk("post_rst_valid", int'(v2), 0);
    chk("post_rst_id", int'(id2), 0);
    chk("post_rst_ei_n", int'(ei2), 0);

    // SC=1, a_n=111 with GS low is code 0: accepted on the 3rd edge.
    do_reset();
    gs_n = 1'b0;
    a_n  = 3'b111;
    push(3'd0, 3);
    accept_check(1, "sc1_code0");

    // SC=2 pending: input changes are ignored, ID held.
    do_reset();
    gs_n = 1'b0;
    a_n  = 3'b100;
    push(3'd3, 4);
    accept_check(2, "sc2_code3");
    a_n = 3'b000;
    steps(3);
    chk("pend_hold_valid", int'(v2), 1);
    chk("pend_hold_id", int'(id2), 3);
    // One-cycle ack with the request still present: 3 BLANK cycles, then
    // re-qualification of code 7 from IDLE (SC edges).
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    chk("ack_valid", int'(v2), 0);
    chk("ack_ei_n", int'(ei2), 0);
    push(3'd7, 5);
    accept_check(2, "requal_code7");

    // Ack held for several cycles is one acknowledge; no request afterwards.
    gs_n    = 1'b1;
    a_n     = 3'b111;
    irq_ack = 1'b1;
    steps(4);
    irq_ack = 1'b0;
    chk("held_ack_valid", int'(v2), 0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (v2) seen = 1'b1;
    end
    chk("held_ack_no_rerise", int'(seen), 0);

    // Ack in IDLE is ignored: a following request qualifies normally.
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    gs_n = 1'b0;
    a_n  = 3'b101;
    push(3'd2, 4);
    accept_check(2, "idle_ack_code2");

    // Ack high on the PEND entry edge is only seen on the next edge.
    do_reset();
    irq_ack = 1'b1;
    gs_n    = 1'b0;
    a_n     = 3'b011;
    push(3'd4, 4);
    accept_check(2, "ack_on_entry");
    step();
    chk("ack_first_pend_cycle", int'(v2), 0);
    irq_ack = 1'b0;

    // SC=3 restart: code 5 for two sampled cycles, then code 6. The change
    // is sampled on edge 5; acceptance on edge 7.
    do_reset();
    gs_n = 1'b0;
    a_n  = 3'b010;
    steps(2);
    a_n = 3'b001;
    push(3'd6, 5);
    accept_check(3, "sc3_restart");

    // SC=3: GS low for only two sampled cycles never reaches PEND, while
    // the SC=2 instance accepts the same pulse.
    do_reset();
    gs_n = 1'b0;
    a_n  = 3'b000;
    steps(2);
    gs_n = 1'b1;
    a_n  = 3'b111;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (v3) seen = 1'b1;
    end
    chk("sc3_short_no_valid", int'(seen), 0);
    chk("sc2_short_valid", int'(v2), 1);
    chk("sc2_short_id", int'(id2), 7);

`ifdef IRQ_CODE_LATCH_MASK_EN
    // Masked code 5 stays in IDLE; unmasking lets it qualify.
    do_reset();
    irq_mask = 8'h20;
    gs_n     = 1'b0;
    a_n      = 3'b010;
    seen     = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (v2) seen = 1'b1;
    end
    chk("mask_no_valid", int'(seen), 0);
    irq_mask = 8'h00;
    n    = 0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      n++;
      if (v2) begin
        seen = 1'b1;
        break;
      end
    end
    chk("unmask_in_window", int'(seen && n >= 2 && n <= 3), 1);
    chk("unmask_id", int'(id2), 5);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
